// File: rtl/adder_accum_pkg.sv
// Shared types for the handshaked adder/accumulator unit.
package adder_accum_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int OPCNT_W = 8;

endpackage

// File: rtl/adder_accum_alu.sv
// Combinational datapath: add, subtract, accumulate, clear.
// ADDACC_SAT_EN selects saturating SUB/ACC instead of wrap-around.
module adder_accum_alu
  import adder_accum_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  mode_t                mode,
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [ACC_WIDTH-1:0] result_nxt,
  output logic [ACC_WIDTH-1:0] acc_nxt,
  output logic                 carry_nxt
);

  localparam int SW = WIDTH + 1;
  localparam int AW = ACC_WIDTH + 1;

  logic [SW-1:0] sum;
  logic [SW-1:0] diff;
  logic [AW-1:0] acc_sum;

  assign sum     = SW'(a) + SW'(b);
  // The top bit of the one-bit-wider difference is the borrow.
  assign diff    = SW'(a) - SW'(b);
  assign acc_sum = AW'(acc) + AW'(a) + AW'(b);

  always_comb begin
    result_nxt = '0;
    acc_nxt    = acc;
    carry_nxt  = 1'b0;
    case (mode)
      MODE_ADD: begin
        result_nxt = ACC_WIDTH'(sum);
        carry_nxt  = sum[WIDTH];
      end
      MODE_SUB: begin
        carry_nxt  = diff[WIDTH];
        result_nxt = ACC_WIDTH'(diff[WIDTH-1:0]);
`ifdef ADDACC_SAT_EN
        if (diff[WIDTH]) result_nxt = '0;
`endif
      end
      MODE_ACC: begin
        carry_nxt = acc_sum[ACC_WIDTH];
        acc_nxt   = acc_sum[ACC_WIDTH-1:0];
`ifdef ADDACC_SAT_EN
        if (acc_sum[ACC_WIDTH]) acc_nxt = '1;
`endif
        result_nxt = acc_nxt;
      end
      MODE_CLR: begin
        acc_nxt = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/adder_accum_unit.sv
// Handshaked adder/accumulator: IDLE -> BUSY -> DONE, result held until consumed.
// Optional saturating arithmetic via ADDACC_SAT_EN (implemented in adder_accum_alu).
module adder_accum_unit
  import adder_accum_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 carry,
  output logic [OPCNT_W-1:0]   op_count,
  output state_t               state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. ready/valid here are decoded from state only, so neither
  // in_valid nor out_ready reaches any output combinationally.

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, b_q;
  mode_t                  mode_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   result_q;
  logic                   carry_q;
  logic [OPCNT_W-1:0]     cnt_q;

  logic [ACC_WIDTH-1:0]   result_nxt, acc_nxt;
  logic                   carry_nxt;
  logic                   accept;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_ready && in_valid;
  assign result    = result_q;
  assign carry     = carry_q;
  assign op_count  = cnt_q;
  assign state_dbg = state_q;

  adder_accum_alu #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_alu (
    .a          (a_q),
    .b          (b_q),
    .mode       (mode_q),
    .acc        (acc_q),
    .result_nxt (result_nxt),
    .acc_nxt    (acc_nxt),
    .carry_nxt  (carry_nxt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_ADD;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= op_a;
        b_q    <= op_b;
        mode_q <= mode_t'(mode);
      end
      if (state_q == ST_BUSY) begin
        result_q <= result_nxt;
        carry_q  <= carry_nxt;
        acc_q    <= acc_nxt;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_accum_unit.sv
// Directed bench for adder_accum_unit (WIDTH=4, ACC_WIDTH=8); expectations follow ADDACC_SAT_EN.
module tb_adder_accum_unit;
  import adder_accum_pkg::*;

  localparam int WIDTH     = 4;
  localparam int ACC_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [1:0]           mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] result;
  logic                 carry;
  logic [7:0]           op_count;
  state_t               state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int exp_acc = 0;

  adder_accum_unit #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .op_count  (op_count),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: called at a negedge in IDLE; returns at the negedge where DONE is visible.
  task automatic issue(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp_res, input logic exp_c, input string tag);
    int waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    mode     = m;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_busy_no_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_carry"}, 32'(carry), 32'(exp_c));
    chk({tag, "_op_count"}, 32'(op_count), 32'(exp_cnt));
  endtask

  // Full op with out_ready high: DONE lasts one cycle, back in IDLE afterwards.
  task automatic op(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                    input logic [7:0] exp_res, input logic exp_c, input string tag);
    issue(m, a, b, exp_res, exp_c, tag);
    @(negedge clk);
    chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
  endtask

  // Scoreboard model for one ACC step of 0xF+0xF.
  task automatic acc_step(input string tag);
    int s;
    logic [7:0] er;
    logic ec;
    s  = exp_acc + 30;
    ec = (s > 255);
`ifdef ADDACC_SAT_EN
    exp_acc = ec ? 255 : s;
`else
    exp_acc = s % 256;
`endif
    er = 8'(exp_acc);
    op(2'b10, 4'hF, 4'hF, er, ec, tag);
  endtask

  initial begin
    logic [7:0] held;
    int         cyc;
    int         done_n;
    int         last_done;
    int         bad_gap;

    reset     = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    mode      = 2'b00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset during BUSY aborts ADD 3+4
    in_valid = 1'b1; mode = 2'b00; op_a = 4'd3; op_b = 4'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_state_busy", 32'(state_dbg), 32'(ST_BUSY));
    reset = 1'b1;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_result", 32'(result), 32'd0);
    chk("mid_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_still_zero", 32'(result), 32'd0);

    // ADD / SUB
    op(2'b00, 4'hF, 4'h1, 8'h10, 1'b1, "add_f_1");
    op(2'b00, 4'h7, 4'h8, 8'h0F, 1'b0, "add_7_8");
`ifdef ADDACC_SAT_EN
    op(2'b01, 4'h2, 4'h5, 8'h00, 1'b1, "sub_2_5");
`else
    op(2'b01, 4'h2, 4'h5, 8'h0D, 1'b1, "sub_2_5");
`endif
    op(2'b01, 4'h9, 4'h3, 8'h06, 1'b0, "sub_9_3");
    op(2'b01, 4'h5, 4'h5, 8'h00, 1'b0, "sub_5_5");

    // CLR then 18 ACC of 0xF+0xF; 9th crosses 255
    op(2'b11, 4'h3, 4'h3, 8'h00, 1'b0, "clr");
    exp_acc = 0;
    for (int i = 1; i <= 18; i++) begin
      acc_step($sformatf("acc%0d", i));
      if (i == 8) chk("acc8_is_240", 32'(result), 32'd240);
      if (i == 9) begin
`ifdef ADDACC_SAT_EN
        chk("acc9_sat", 32'(result), 32'hFF);
`else
        chk("acc9_wrap", 32'(result), 32'h0E);
`endif
      end
    end
    // ADD must not disturb the accumulator
    op(2'b00, 4'h1, 4'h2, 8'h03, 1'b0, "add_keep_acc");
`ifdef ADDACC_SAT_EN
    op(2'b10, 4'h0, 4'h1, 8'hFF, 1'b1, "acc_after_add");
`else
    // wrap: 18*30 mod 256 = 28, +1 = 29
    op(2'b10, 4'h0, 4'h1, 8'h1D, 1'b0, "acc_after_add");
`endif

    // Backpressure: hold DONE for 5 cycles, poke in_valid meanwhile
    out_ready = 1'b0;
    issue(2'b00, 4'h9, 4'h9, 8'h12, 1'b1, "bp");
    held = result;
    in_valid = 1'b1; mode = 2'b11; op_a = 4'h1; op_b = 4'h1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold_ready%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp_hold_result%0d", k), 32'(result), 32'(held));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_no_extra_op", 32'(op_count), 32'(exp_cnt));
    chk("bp_result_kept", 32'(result), 32'h12);

    // op_count wrap: reset, then 256 back-to-back ADDs with in_valid held high
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    in_valid = 1'b1; mode = 2'b00; op_a = 4'h1; op_b = 4'h2;
    cyc = 0; done_n = 0; last_done = -1; bad_gap = 0;
    while (done_n < 256 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (last_done >= 0 && cyc - last_done != 3) bad_gap++;
        last_done = cyc;
        done_n++;
      end
    end
    in_valid = 1'b0;
    chk("wrap_completions", 32'(done_n), 32'd256);
    chk("wrap_last_cycle", 32'(cyc), 32'd767);
    chk("wrap_interval_gaps", 32'(bad_gap), 32'd0);
    chk("wrap_op_count", 32'(op_count), 32'd0);
    chk("wrap_result", 32'(result), 32'h03);
    @(negedge clk);
    chk("wrap_idle", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_accum_unit.md
# adder_accum_unit

Parametrised, handshaked arithmetic unit that replaces the fixed two-nibble registered adder in the user tile. It accepts two WIDTH-bit operands and a mode through a valid/ready input port. It computes add, subtract or accumulate into an internal ACC_WIDTH-bit accumulator, and holds the registered result on a valid/ready output port until the result is consumed. It sits between the tile's input-pin decode and output-pin drive logic.

## Interface
- WIDTH, 4: operand width in bits; legal range 2..16.
- ACC_WIDTH, 8: accumulator and result width in bits; must be ≥ WIDTH+1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/mode presented.
- in_ready  out  1  unit can accept a new operation.
- op_a  in  WIDTH  first operand, unsigned.
- op_b  in  WIDTH  second operand, unsigned.
- mode  in  2  operation select: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- out_valid  out  1  result, carry and op_count are valid.
- out_ready  in  1  downstream consumes the result.
- result  out  ACC_WIDTH  registered result.
- carry  out  1  carry out (ADD, ACC) or borrow (SUB).
- op_count  out  8  number of completed operations; wraps 255→0.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: one compute cycle.
  - DONE: out_valid=1.
- State transitions:
  - IDLE→BUSY when in_valid&in_ready; op_a, op_b and mode are latched on that edge.
  - BUSY→DONE unconditionally; result, carry and accumulator are written on this edge, and op_count increments.
  - DONE→IDLE when out_ready=1. With out_ready=0 the unit stays in DONE, outputs are stable and in_ready=0.
- ADD:
  - result = zero-extended op_a+op_b; carry = sum bit WIDTH.
  - The full WIDTH+1-bit sum is also present in result.
  - Accumulator is unchanged.
- SUB:
  - result = (op_a−op_b) mod 2^WIDTH, zero-extended; carry = borrow (op_a<op_b).
  - Accumulator is unchanged.
- ACC:
  - acc ← (acc+op_a+op_b) mod 2^ACC_WIDTH; result = new acc; carry = carry out of bit ACC_WIDTH−1.
- CLR: acc←0, result=0, carry=0.
- Inputs are ignored outside IDLE; in_valid held high in BUSY/DONE has no effect.
- Reset values, applied at any time and aborting any in-flight operation:
  - state=IDLE, in_ready=1 (combinational from state), out_valid=0.
  - result=0, carry=0, acc=0, op_count=0.

## Timing
- Acceptance edge N; BUSY during N→N+1; result registered at edge N+1; out_valid high from N+1.
- Minimum latency from accept to out_valid: 1 cycle.
- Minimum issue interval: 3 cycles (IDLE, BUSY, DONE) with out_ready tied high.
- in_ready and out_valid are pure functions of state; there is no combinational path from in_valid or out_ready to any output.
- out_ready asserted at the same edge that out_valid first rises is honoured: DONE lasts exactly one cycle.

## Configuration
- ADDACC_SAT_EN defined, saturating arithmetic:
  - SUB with borrow yields result=0.
  - ACC overflow yields acc=result=2^ACC_WIDTH−1.
  - carry still reports the borrow/overflow event.
  - ADD is unaffected, since its result always fits.
- ADDACC_SAT_EN undefined: wrap-around arithmetic exactly as in Operation.

## Structure
- Package adder_accum_pkg holds:
  - the mode enum: MODE_ADD, MODE_SUB, MODE_ACC, MODE_CLR;
  - the state enum: ST_IDLE, ST_BUSY, ST_DONE;
  - the op_count width constant (8).
- Sub-module adder_accum_alu is a purely combinational datapath:
  - inputs: latched operands, mode, current acc;
  - outputs: next result, next acc, carry;
  - contains all saturation logic under ADDACC_SAT_EN.
- The top holds the FSM, operand latches, accumulator and counter.

## Test plan
All scenarios use WIDTH=4, ACC_WIDTH=8.
- Reset mid-operation: accept ADD 3+4, then assert reset during BUSY → out_valid=0, result=0, op_count=0, and in_ready=1 after release.
- ADD: 0xF+0x1 → result=0x10, carry=1, out_valid one cycle after accept, op_count=1.
- SUB: 2−5, wrap build → result=0x0D, carry=1. SAT build → result=0x00, carry=1.
- ACC overflow:
  - first, CLR, then 18 ACC ops of 0xF+0xF, each adding 30;
  - the 9th ACC (acc 240→14) → carry=1, result=0x0E in the wrap build;
  - in the SAT build, acc reaches 240 after 8 ops, the 9th gives 0xFF with carry=1, and later ops stay 0xFF.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result stable, in_ready=0, a new in_valid is ignored; on release, DONE→IDLE in 1 cycle.
- op_count wrap: 256 ADD ops with out_ready=1 → op_count returns to 0; issue interval is exactly 3 cycles.
